// File: rtl/muldiv_pkg.sv
// Shared encodings for the MULT/MULTU/DIV/DIVU sequencer: funct[1:0] op codes,
// controller states and the iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_e;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned CNT_W        = $clog2(MULDIV_WIDTH) + 1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step (LSB first) or
// restoring-division step (MSB first, remainder kept in acc[WIDTH:0]).
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [2*WIDTH-1:0] sh_in,
  input  logic [WIDTH-1:0]   bits_in,
  output logic [2*WIDTH-1:0] acc_out,
  output logic [2*WIDTH-1:0] sh_out,
  output logic [WIDTH-1:0]   bits_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted  = {acc_in[WIDTH-1:0], bits_in[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, sh_in[WIDTH-1:0]};
    acc_out  = '0;
    sh_out   = sh_in;
    bits_out = bits_in;
    if (is_div) begin
      // diff[WIDTH+1] is the borrow: trial subtract failed, keep shifted remainder
      acc_out[WIDTH:0] = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
      bits_out         = {bits_in[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      // Multiplicand shifts left so a partial run still leaves an aligned product
      acc_out  = acc_in + (bits_in[0] ? sh_in : '0);
      sh_out   = {sh_in[2*WIDTH-2:0], 1'b0};
      bits_out = {1'b0, bits_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller with hi/lo write strobe and fetch stall.
// Optional macro MULDIV_EARLY_OUT_EN: multiply RUN ends once remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             hi_lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             stall,
  output logic             div_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e             state, state_nx;
  logic [CW-1:0]      count;
  op_e                op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] acc, sh;
  logic [WIDTH-1:0]   bits;

  logic               is_div, is_signed, run_last;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] step_acc, step_sh;
  logic [WIDTH-1:0]   step_bits;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_dz;

  assign is_div    = op_is_div(op_r);
  assign is_signed = op_is_signed(op_r);
  assign a_abs     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
  assign b_abs     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc_in   (acc),
    .sh_in    (sh),
    .bits_in  (bits),
    .acc_out  (step_acc),
    .sh_out   (step_sh),
    .bits_out (step_bits)
  );

`ifdef MULDIV_EARLY_OUT_EN
  assign run_last = (count == CW'(WIDTH-1)) || (!is_div && (step_bits == '0));
`else
  assign run_last = (count == CW'(WIDTH-1));
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_PREP;
      S_PREP:  state_nx = S_RUN;
      S_RUN:   if (run_last) state_nx = S_FIXUP;
      S_FIXUP: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Result fix-up: sign correction, with divide-by-zero overriding the raw quotient
  always_comb begin
    prod   = neg_q ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    fix_dz = 1'b0;
    if (is_div) begin
      if (b_r == '0) begin
        fix_hi = a_r;
        fix_lo = '1;
        fix_dz = 1'b1;
      end else begin
        fix_hi = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_lo = neg_q ? -bits : bits;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      op_r     <= OP_MULT;
      a_r      <= '0;
      b_r      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      sh       <= '0;
      bits     <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op_e'(op);
            a_r  <= operand_a;
            b_r  <= operand_b;
          end
        end
        S_PREP: begin
          count <= '0;
          neg_q <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r <= is_signed & a_r[WIDTH-1];
          acc   <= '0;
          bits  <= is_div ? a_abs : b_abs;
          sh    <= {{WIDTH{1'b0}}, (is_div ? b_abs : a_abs)};
        end
        S_RUN: begin
          acc   <= step_acc;
          sh    <= step_sh;
          bits  <= step_bits;
          count <= count + CW'(1);
        end
        S_FIXUP: begin
          hi_out   <= fix_hi;
          lo_out   <= fix_lo;
          div_zero <= fix_dz;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == S_RUN) || (state == S_FIXUP);
  assign stall    = busy;
  assign done     = (state == S_DONE);
  assign hi_lo_we = done;

endmodule
